// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS-style controller:
// opcodes, funct codes, datapath select encodings and state codes.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR = 6'h08;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_ADDI = 3'b100;
  localparam logic [2:0] ALU_ORI  = 3'b101;
  localparam logic [2:0] ALU_ANDI = 3'b110;
  localparam logic [2:0] ALU_LUI  = 3'b011;
  localparam logic [2:0] ALU_FN   = 3'b111;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REGA   = 2'b11;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_EXEC_I   = 4'd8;
  localparam logic [3:0] S_I_WB     = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_JR       = 4'd12;

  typedef enum logic [2:0] {
    CL_MEM,
    CL_R,
    CL_JR,
    CL_I,
    CL_BR,
    CL_J,
    CL_ILL
  } op_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle; master is the controller,
// slave is the datapath side.
interface multicycle_control_if;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       Link;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;

  modport master (
    input  OP, Funct, Zero, mem_ready,
    output PCWrite, IorD, MemRead, MemWrite,
    output IRWrite, MemtoReg, RegDst, RegWrite,
    output ALUSrcA, Link, ALUSrcB, ALUOp, PCSource
  );

  modport slave (
    output OP, Funct, Zero, mem_ready,
    input  PCWrite, IorD, MemRead, MemWrite,
    input  IRWrite, MemtoReg, RegDst, RegWrite,
    input  ALUSrcA, Link, ALUSrcB, ALUOp, PCSource
  );
endinterface

// File: rtl/multicycle_control_op_class.sv
// Combinational OP/Funct to instruction-class decoder.
module multicycle_op_class
  import multicycle_control_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output op_class_t  cls
);

  always_comb begin
    cls = CL_ILL;
    unique case (1'b1)
      (op == OP_LW),
      (op == OP_SW):     cls = CL_MEM;
      (op == OP_RTYPE):  cls = (funct == FN_JR) ? CL_JR : CL_R;
      (op == OP_ADDI),
      (op == OP_ANDI),
      (op == OP_ORI),
      (op == OP_LUI):    cls = CL_I;
      (op == OP_BEQ),
      (op == OP_BNE):    cls = CL_BR;
      (op == OP_J),
      (op == OP_JAL):    cls = CL_J;
      default:           cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller FSM with memory handshake waits and a
// retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus,
  output logic                illegal_op,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    instr_count
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] out_st;
  logic       retire;
  op_class_t  cls;

  multicycle_op_class u_cls (
    .op    (bus.OP),
    .funct (bus.Funct),
    .cls   (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:
        state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (cls)
          CL_MEM:  state_d = S_MEM_ADDR;
          CL_R:    state_d = S_EXEC_R;
          CL_JR:   state_d = S_JR;
          CL_I:    state_d = S_EXEC_I;
          CL_BR:   state_d = S_BRANCH;
          CL_J:    state_d = S_JUMP;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        state_d = (bus.OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:
        state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:
        state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R: state_d = S_R_WB;
      S_EXEC_I: state_d = S_I_WB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Reset forces FETCH-state outputs even before the first edge.
  assign out_st = reset ? S_FETCH : state_q;

  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegDst   = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.Link     = 1'b0;
    bus.ALUSrcB  = SRCB_B;
    bus.ALUOp    = 3'b000;
    bus.PCSource = PCS_ALU;
    illegal_op   = 1'b0;
    case (out_st)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_4;
        bus.ALUOp   = ALU_ADD;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALUSrcB = SRCB_IMM2;
        bus.ALUOp   = ALU_ADD;
        illegal_op  = (cls == CL_ILL);
      end
      S_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALU_ADD;
      end
      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEM_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALU_FN;
      end
      S_R_WB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        case (bus.OP)
          OP_ORI:  bus.ALUOp = ALU_ORI;
          OP_ANDI: bus.ALUOp = ALU_ANDI;
          OP_LUI:  bus.ALUOp = ALU_LUI;
          default: bus.ALUOp = ALU_ADDI;
        endcase
      end
      S_I_WB: bus.RegWrite = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUOp    = ALU_SUB;
        bus.PCSource = PCS_ALUOUT;
        bus.PCWrite  = (bus.OP == OP_BNE) ? ~bus.Zero : bus.Zero;
      end
      S_JUMP: begin
        bus.PCSource = PCS_JUMP;
        bus.PCWrite  = 1'b1;
        bus.RegWrite = (bus.OP == OP_JAL);
        bus.Link     = (bus.OP == OP_JAL);
      end
      S_JR: begin
        bus.PCSource = PCS_REGA;
        bus.PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  // Illegal DECODE and codes 13-15 return to FETCH without retiring.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEM_WB, S_R_WB, S_I_WB,
      S_BRANCH, S_JUMP, S_JR: retire = 1'b1;
      S_MEM_WR:               retire = bus.mem_ready;
      default:                retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)       instr_count <= '0;
    else if (retire) instr_count <= instr_count + 1'b1;
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a 4-bit retire counter.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic       illegal_op;
  logic [3:0] state;
  logic [3:0] instr_count;
  int         n_cmp;
  int         n_err;

  multicycle_control_if bus ();

  multicycle_control #(.CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .illegal_op  (illegal_op),
    .state       (state),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.OP = 6'h00;
    bus.Funct = 6'h20;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b1;
    step();
    step();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_cnt", 8'(instr_count), 8'd0);
    chk("rst_memread", 8'(bus.MemRead), 8'd1);
    chk("rst_srcb", 8'(bus.ALUSrcB), 8'd1);
    chk("rst_irwrite", 8'(bus.IRWrite), 8'd1);
    reset = 1'b0;

    // FETCH wait
    bus.mem_ready = 1'b0;
    step();
    chk("fetch_wait_st", 8'(state), 8'd0);
    chk("fetch_wait_ir", 8'(bus.IRWrite), 8'd0);
    chk("fetch_wait_pcw", 8'(bus.PCWrite), 8'd0);

    // ADDI
    bus.mem_ready = 1'b1;
    bus.OP = 6'h08;
    step();
    chk("addi_dec", 8'(state), 8'd1);
    chk("addi_dec_srcb", 8'(bus.ALUSrcB), 8'd3);
    step();
    chk("addi_exec", 8'(state), 8'd8);
    chk("addi_aluop", 8'(bus.ALUOp), 8'b100);
    chk("addi_srcb", 8'(bus.ALUSrcB), 8'd2);
    step();
    chk("addi_wb", 8'(state), 8'd9);
    chk("addi_regw", 8'(bus.RegWrite), 8'd1);
    step();
    chk("addi_fetch", 8'(state), 8'd0);
    chk("addi_cnt", 8'(instr_count), 8'd1);

    // ORI
    bus.OP = 6'h0D;
    step();
    step();
    chk("ori_aluop", 8'(bus.ALUOp), 8'b101);
    step();
    step();
    chk("ori_cnt", 8'(instr_count), 8'd2);

    // LW with two wait cycles
    bus.OP = 6'h23;
    step();
    step();
    chk("lw_addr", 8'(state), 8'd2);
    chk("lw_addr_srca", 8'(bus.ALUSrcA), 8'd1);
    bus.mem_ready = 1'b0;
    step();
    chk("lw_rd1", 8'(state), 8'd3);
    chk("lw_rd1_ctl", 8'({bus.MemRead, bus.IorD}), 8'b11);
    step();
    chk("lw_rd2", 8'(state), 8'd3);
    step();
    chk("lw_rd3", 8'(state), 8'd3);
    chk("lw_rd3_ctl", 8'({bus.MemRead, bus.IorD}), 8'b11);
    bus.mem_ready = 1'b1;
    step();
    chk("lw_wb", 8'(state), 8'd4);
    chk("lw_wb_ctl", 8'({bus.MemtoReg, bus.RegWrite, bus.RegDst}),
        8'b110);
    step();
    chk("lw_cnt", 8'(instr_count), 8'd3);

    // BEQ Zero=0, then BNE Zero=0
    bus.OP = 6'h04;
    step();
    step();
    chk("beq_st", 8'(state), 8'd10);
    chk("beq_pcw", 8'(bus.PCWrite), 8'd0);
    chk("beq_pcs", 8'(bus.PCSource), 8'd1);
    chk("beq_aluop", 8'(bus.ALUOp), 8'b001);
    step();
    chk("beq_cnt", 8'(instr_count), 8'd4);
    bus.OP = 6'h05;
    step();
    step();
    chk("bne_pcw", 8'(bus.PCWrite), 8'd1);
    step();
    chk("bne_cnt", 8'(instr_count), 8'd5);

    // JAL
    bus.OP = 6'h03;
    step();
    step();
    chk("jal_st", 8'(state), 8'd11);
    chk("jal_ctl", 8'({bus.PCWrite, bus.RegWrite, bus.Link}), 8'b111);
    chk("jal_pcs", 8'(bus.PCSource), 8'd2);
    step();

    // JR
    bus.OP = 6'h00;
    bus.Funct = 6'h08;
    step();
    step();
    chk("jr_st", 8'(state), 8'd12);
    chk("jr_pcs", 8'(bus.PCSource), 8'd3);
    chk("jr_pcw", 8'(bus.PCWrite), 8'd1);
    step();
    chk("jr_cnt", 8'(instr_count), 8'd7);

    // R-type add
    bus.Funct = 6'h20;
    step();
    step();
    chk("r_exec", 8'(state), 8'd6);
    chk("r_aluop", 8'(bus.ALUOp), 8'b111);
    step();
    chk("r_wb", 8'({bus.RegDst, bus.RegWrite}), 8'b11);
    step();
    chk("r_cnt", 8'(instr_count), 8'd8);

    // Illegal opcode
    bus.OP = 6'h3F;
    step();
    chk("ill_dec", 8'(state), 8'd1);
    chk("ill_pulse", 8'(illegal_op), 8'd1);
    step();
    chk("ill_fetch", 8'(state), 8'd0);
    chk("ill_clear", 8'(illegal_op), 8'd0);
    chk("ill_cnt", 8'(instr_count), 8'd8);

    // SW interrupted by reset
    bus.OP = 6'h2B;
    step();
    step();
    bus.mem_ready = 1'b0;
    step();
    chk("sw_wr", 8'(state), 8'd5);
    chk("sw_memw", 8'(bus.MemWrite), 8'd1);
    reset = 1'b1;
    step();
    chk("sw_rst_st", 8'(state), 8'd0);
    chk("sw_rst_memw", 8'(bus.MemWrite), 8'd0);
    chk("sw_rst_cnt", 8'(instr_count), 8'd0);
    reset = 1'b0;
    bus.mem_ready = 1'b1;

    // Counter wrap: 16 jumps
    bus.OP = 6'h02;
    for (int i = 0; i < 16; i++) begin
      step();
      step();
      step();
      if (i == 14) chk("wrap_15", 8'(instr_count), 8'd15);
    end
    chk("wrap_0", 8'(instr_count), 8'd0);
    chk("wrap_st", 8'(state), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 OP  in  6  opcode from the instruction register; stable from DECODE until the return to FETCH.
REQ-005 Funct  in  6  funct field from the instruction register; same stability as OP.
REQ-006 Zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory handshake: access completes in a cycle with MemRead or MemWrite high and mem_ready=1.
REQ-008 PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, Link  out  1 each  datapath controls (Link selects $31 as destination and PC as write data).
REQ-009 ALUSrcB  out  2  00=B, 01=4, 10=sign-extended immediate, 11=sign-extended immediate<<2.
REQ-010 ALUOp  out  3  010=add, 001=sub, 100=addi, 101=ori, 110=andi, 011=lui, 111=R-type funct.
REQ-011 PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=register A.
REQ-012 illegal_op  out  1  one-cycle pulse for an unsupported opcode.
REQ-013 state  out  4  current state code, for debug.
REQ-014 instr_count  out  CNT_W  retired-instruction count.

Function
REQ-015 States and codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11, JR=12; codes 13-15 shall go to FETCH on the next edge with all outputs deasserted.
REQ-016 Outputs not listed for a state shall be 0.
REQ-017 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00; IRWrite=PCWrite=mem_ready; stay in FETCH while mem_ready=0, go to DECODE when mem_ready=1.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=010.
REQ-019 DECODE next state: LW(23h) or SW(2Bh) -> MEM_ADDR; R-type(00h) with Funct=08h -> JR; other R-type -> EXEC_R; ADDI(08h), ANDI(0Ch), ORI(0Dh) or LUI(0Fh) -> EXEC_I; BEQ(04h) or BNE(05h) -> BRANCH; J(02h) or JAL(03h) -> JUMP.
REQ-020 Any other opcode in DECODE: illegal_op=1 for that cycle, next state FETCH, instr_count unchanged.
REQ-021 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=010; next MEM_RD for LW, MEM_WR for SW.
REQ-022 MEM_RD: MemRead=1, IorD=1; hold until mem_ready=1, then MEM_WB.
REQ-023 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
REQ-024 MEM_WR: MemWrite=1, IorD=1; hold until mem_ready=1, then FETCH.
REQ-025 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111; then R_WB. R_WB: RegDst=1, RegWrite=1; then FETCH.
REQ-026 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp by opcode (ADDI 100, ORI 101, ANDI 110, LUI 011); then I_WB. I_WB: RegWrite=1, RegDst=0, MemtoReg=0; then FETCH.
REQ-027 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01; PCWrite=Zero for BEQ and ~Zero for BNE, evaluated in the same cycle; then FETCH.
REQ-028 JUMP: PCSource=10, PCWrite=1; for JAL, also RegWrite=1 and Link=1 (writes the already-incremented PC to $31); then FETCH.
REQ-029 JR: PCSource=11, PCWrite=1; then FETCH.
REQ-030 instr_count shall increment by 1 on each edge that moves from a non-FETCH state to FETCH, except the illegal path (REQ-020) and codes 13-15; it wraps from 2^CNT_W-1 to 0.
REQ-031 Latency in cycles with mem_ready=1 from FETCH entry: LW 5, SW 4, R/I-type 4, BEQ/BNE 3, J/JAL/JR 3; each memory wait cycle adds 1.

Reset
REQ-032 reset=1 at an edge shall force state=FETCH and instr_count=0, overriding mem_ready and any pending transition.
REQ-033 During and after reset, outputs shall be the FETCH-state values; a MemWrite or RegWrite in progress shall deassert on the first reset edge.

Structure
REQ-034 A shared package shall hold the opcode and funct constants, the ALUOp, ALUSrcB and PCSource encodings, and the state codes.
REQ-035 One sub-module, multicycle_op_class, shall be the combinational OP/Funct-to-instruction-class decoder used by the DECODE next-state logic.

Verification
REQ-036 ADDI (OP=08h), mem_ready=1 -> states 0,1,8,9,0; I_WB has RegWrite=1, ALUOp=100 in EXEC_I; instr_count 0->1.
REQ-037 LW with mem_ready low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles with MemRead=1, IorD=1, then MEM_WB with MemtoReg=1.
REQ-038 BEQ with Zero=0, then BNE with Zero=0 -> PCWrite=0 in the first BRANCH cycle, PCWrite=1 in the second; both increment instr_count.
REQ-039 JAL (03h) -> JUMP has PCWrite=1, RegWrite=1, Link=1, PCSource=10; R-type with Funct=08h -> JR with PCSource=11.
REQ-040 OP=3Fh -> illegal_op pulses for 1 cycle in DECODE, next state FETCH, instr_count unchanged.
REQ-041 reset asserted in MEM_WR with mem_ready=0 -> next cycle state=0, MemWrite=0, instr_count=0; with CNT_W=4, 16 retirements -> instr_count returns to 0.
